// File: rtl/uart_rx.sv
// UART receiver: two-flop input synchroniser, 16x oversampled start/data/stop
// sampling at mid-bit, framing-error flag and a break guard that forces the
// line back high before another frame can start.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            S_tick,
    input  logic            rx,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            busy
);

    // Tick counter must cover both the 16-tick bit period and the stop length.
    localparam int S_MAX = (SB_TICK - 1 > 15) ? SB_TICK - 1 : 15;
    localparam int SW    = $clog2(S_MAX + 1);
    localparam int NW    = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_ferr;
    logic            r_busy;
    logic            r_sync_1;
    logic            r_sync_2;
    logic            w_rx_s;

    assign w_rx_s = r_sync_2;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
        end else begin
            r_sync_1 <= rx;
            r_sync_2 <= r_sync_1;
        end
    end

    // Frame FSM with counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A falling edge starts a frame; no tick needed to leave.
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_s     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (S_tick) begin
                        if (r_s == S_MID) begin
                            if (!w_rx_s) begin
                                r_state <= DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                // Line went back high before mid-start: glitch.
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (S_tick) begin
                        if (r_s == S_LAST) begin
                            r_s     <= '0;
                            r_shift <= {w_rx_s, r_shift[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n <= r_n + NW'(1);
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (S_tick) begin
                        if (r_s == S_STOP) begin
                            r_dout <= r_shift;
                            r_ferr <= ~w_rx_s;
                            r_done <= 1'b1;
                            if (w_rx_s) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= WAIT_HI;
                            end
                        end else begin
                            r_s <= r_s + SW'(1);
                        end
                    end
                end
                WAIT_HI: begin
                    // Break guard: a low line must return high before re-arming.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_dout      = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
    assign busy         = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: S_tick every 4 clks, 16 ticks per bit, scoreboard of
// expected {frame_err, data} entries popped on every done pulse.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       S_tick;
    logic       rx;
    logic [7:0] rx_dout;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    int         total;
    int         bad;
    int         cyc;
    int         done_n;
    int         done_cyc [0:15];
    int         tcnt;
    logic [8:0] sb [$];

    uart_rx #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .S_tick       (S_tick),
        .rx           (rx),
        .rx_dout      (rx_dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // 16x strobe: one clk high out of every four.
    initial begin
        tcnt   = 0;
        S_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt   = (tcnt + 1) % 4;
            S_tick = (tcnt == 0);
        end
    end

    // Output monitor: every done pulse pops and checks one scoreboard entry.
    initial begin
        logic [8:0] e;
        done_n = 0;
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                if (done_n < 16) done_cyc[done_n] = cyc;
                done_n++;
                $display("done #%0d at cyc %0d: data=%02h frame_err=%0b", done_n, cyc, rx_dout, frame_err);
                chk("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rx_dout", 32'(rx_dout), 32'(e[7:0]));
                    chk("frame_err", 32'(frame_err), 32'(e[8]));
                    if (!e[8]) begin
                        @(negedge clk);
                        chk("busy_after_done", 32'(busy), 0);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b, input int nticks);
        rx = b;
        repeat (nticks * 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bit(d[i], 16);
        send_bit(stop_b, 16);
    endtask

    initial begin
        int k;
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst   = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_dout", 32'(rx_dout), 0);
        chk("rst_done", 32'(rx_done_tick), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        send_bit(1'b1, 8);

        // 1: good frame
        sb.push_back({1'b0, 8'hA5});
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1, 8);

        // 2: short glitch on the line, no frame
        send_bit(1'b0, 3);
        send_bit(1'b1, 20);
        chk("glitch_busy", 32'(busy), 0);
        chk("glitch_dout", 32'(rx_dout), 32'h A5);
        chk("glitch_ferr", 32'(frame_err), 0);

        // 3: stop bit low, then recovery with a good frame
        sb.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0);
        chk("wait_hi_busy", 32'(busy), 1);
        chk("wait_hi_ferr", 32'(frame_err), 1);
        send_bit(1'b1, 20);
        chk("wait_hi_released", 32'(busy), 0);
        chk("ferr_held", 32'(frame_err), 1);
        sb.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1);
        send_bit(1'b1, 20);
        chk("ferr_cleared", 32'(frame_err), 0);

        // 4: back-to-back frames, no idle gap
        k = done_n;
        sb.push_back({1'b0, 8'h00});
        sb.push_back({1'b0, 8'hFF});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1, 20);
        chk("b2b_count", 32'(done_n - k), 2);
        if (done_n - k == 2) chk("b2b_gap_clks", 32'(done_cyc[k+1] - done_cyc[k]), 640);

        // 5: reset during data bit 4 of 0x81
        k = done_n;
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 8);
        chk("busy_mid_frame", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("abort_dout", 32'(rx_dout), 0);
        chk("abort_ferr", 32'(frame_err), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(rx_done_tick), 0);
        repeat (3) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        send_bit(1'b1, 20);
        chk("abort_no_done", 32'(done_n - k), 0);
        sb.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1);
        send_bit(1'b1, 20);
        chk("after_abort_dout", 32'(rx_dout), 32'h81);

        // 6: break condition, 30 bit-times low
        k = done_n;
        sb.push_back({1'b1, 8'h00});
        send_bit(1'b0, 480);
        chk("break_one_done", 32'(done_n - k), 1);
        chk("break_busy", 32'(busy), 1);
        send_bit(1'b1, 32);
        chk("break_released", 32'(busy), 0);
        chk("break_no_more_done", 32'(done_n - k), 1);

        chk("done_total", 32'(done_n), 7);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
